fp_align_unpack: RTL and testbench

- Front-end partner of the FP32 adder's round/normalize/pack back end. Accepts two IEEE-754 singles and unpacks them.
- Orders the operands by magnitude, aligns the smaller mantissa to the larger exponent with a sticky bit, and converts both to two's complement.
- Emits the {large, small, sticky, exponent} bundle the adder consumes.
- 3-stage valid/ready pipeline; also flags NaN/Inf cases and supplies their final result directly.

---
 rtl/fp_pkg.sv | 29 ++
 rtl/fp_shr_sticky.sv | 24 ++
 rtl/fp_align_unpack.sv | 128 ++++++++++++
 tb/tb_fp_align_unpack.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_pkg.sv
// Shared FP32 definitions for the adder front end (align/unpack) and back end (round/pack).
package fp_pkg;

  localparam int EXP_W  = 8;
  localparam int FRAC_W = 23;
  localparam int GRD_W  = 2;
  localparam int MAN_W  = FRAC_W + GRD_W + 2;

  localparam logic [31:0] QNAN = 32'h7FC00000;

  // Aligned operand bundle handed from the front end to the back end
  typedef struct packed {
    logic [MAN_W-1:0] large_n;
    logic [MAN_W-1:0] small_n;
    logic             sticky;
    logic [EXP_W-1:0] exp_l;
    logic             special;
    logic [31:0]      special_res;
  } fp_align_t;

  function automatic logic isNan(input logic [31:0] x);
    return (&x[30:23]) && (|x[22:0]);
  endfunction

  function automatic logic isInf(input logic [31:0] x);
    return (&x[30:23]) && !(|x[22:0]);
  endfunction

endpackage

// File: rtl/fp_shr_sticky.sv
// Combinational right shifter that saturates large shift amounts and reports lost bits as sticky.
module fp_shr_sticky
  import fp_pkg::*;
(
  input  logic [MAN_W-1:0] data_i,
  input  logic [EXP_W-1:0] amt_i,
  output logic [MAN_W-1:0] data_o,
  output logic             sticky_o
);

  logic [2*MAN_W-1:0] wide;

  // Shift into a double-width window; the lower half collects everything that fell off
  always_comb begin
    wide     = {data_i, {MAN_W{1'b0}}} >> amt_i;
    data_o   = wide[2*MAN_W-1:MAN_W];
    sticky_o = |wide[MAN_W-1:0];
    if (amt_i >= EXP_W'(MAN_W)) begin
      data_o   = '0;
      sticky_o = |data_i;
    end
  end

endmodule

// File: rtl/fp_align_unpack.sv
// FP32 adder front end: classify/swap, align with sticky, and convert to two's complement in 3 stages.
module fp_align_unpack
  import fp_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [31:0]         a,
  input  logic [31:0]         b,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [MAN_W-1:0]    large_n,
  output logic [MAN_W-1:0]    small_n,
  output logic                sticky,
  output logic [EXP_W-1:0]    exp_l,
  output logic                special,
  output logic [31:0]         special_res
);

  logic advance;

  logic [31:0]       opL, opS;
  logic [EXP_W-1:0]  effL, effS;
  logic [FRAC_W:0]   manL_d, manS_d;
  logic [EXP_W-1:0]  dist_d;
  logic              spec_d;
  logic [31:0]       specRes_d;

  logic              v1_q, sgnL1_q, sgnS1_q, spec1_q;
  logic [FRAC_W:0]   manL1_q, manS1_q;
  logic [EXP_W-1:0]  dist1_q, exp1_q;
  logic [31:0]       specRes1_q;

  logic [MAN_W-1:0]  smallMag_d;
  logic              sticky_d;

  logic              v2_q, sgnL2_q, sgnS2_q, spec2_q, sticky2_q;
  logic [MAN_W-1:0]  largeMag2_q, smallMag2_q;
  logic [EXP_W-1:0]  exp2_q;
  logic [31:0]       specRes2_q;

  logic              v3_q;
  fp_align_t         out_q;

  // Every stage moves together whenever the output slot is free or being drained
  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;

  // Stage 1 classify: order by magnitude (ties keep a as the larger), unpack, and spot NaN/Inf
  always_comb begin
    opL       = (a[30:0] >= b[30:0]) ? a : b;
    opS       = (a[30:0] >= b[30:0]) ? b : a;
    effL      = (opL[30:23] == '0) ? EXP_W'(1) : opL[30:23];
    effS      = (opS[30:23] == '0) ? EXP_W'(1) : opS[30:23];
    manL_d    = {|opL[30:23], opL[22:0]};
    manS_d    = {|opS[30:23], opS[22:0]};
    dist_d    = effL - effS;
    spec_d    = 1'b0;
    specRes_d = '0;
    if (isNan(a) || isNan(b) || (isInf(a) && isInf(b) && (a[31] != b[31]))) begin
      spec_d    = 1'b1;
      specRes_d = QNAN;
    end else if (isInf(a)) begin
      spec_d    = 1'b1;
      specRes_d = a;
    end else if (isInf(b)) begin
      spec_d    = 1'b1;
      specRes_d = b;
    end
  end

  // Stage 1 register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q <= 1'b0; sgnL1_q <= 1'b0; sgnS1_q <= 1'b0; spec1_q <= 1'b0;
      manL1_q <= '0; manS1_q <= '0; dist1_q <= '0; exp1_q <= '0; specRes1_q <= '0;
    end else if (advance) begin
      v1_q <= in_valid; sgnL1_q <= opL[31]; sgnS1_q <= opS[31]; spec1_q <= spec_d;
      manL1_q <= manL_d; manS1_q <= manS_d; dist1_q <= dist_d; exp1_q <= effL;
      specRes1_q <= specRes_d;
    end
  end

  fp_shr_sticky u_shr (
    .data_i   ({1'b0, manS1_q, {GRD_W{1'b0}}}),
    .amt_i    (dist1_q),
    .data_o   (smallMag_d),
    .sticky_o (sticky_d)
  );

  // Stage 2 register: aligned magnitudes with guard bits appended
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v2_q <= 1'b0; sgnL2_q <= 1'b0; sgnS2_q <= 1'b0; spec2_q <= 1'b0; sticky2_q <= 1'b0;
      largeMag2_q <= '0; smallMag2_q <= '0; exp2_q <= '0; specRes2_q <= '0;
    end else if (advance) begin
      v2_q <= v1_q; sgnL2_q <= sgnL1_q; sgnS2_q <= sgnS1_q; spec2_q <= spec1_q;
      sticky2_q <= sticky_d; largeMag2_q <= {1'b0, manL1_q, {GRD_W{1'b0}}};
      smallMag2_q <= smallMag_d; exp2_q <= exp1_q; specRes2_q <= specRes1_q;
    end
  end

  // Stage 3 register: apply signs in two's complement and present the bundle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v3_q  <= 1'b0;
      out_q <= '0;
    end else if (advance) begin
      v3_q              <= v2_q;
      out_q.large_n     <= sgnL2_q ? (~largeMag2_q + MAN_W'(1)) : largeMag2_q;
      out_q.small_n     <= sgnS2_q ? (~smallMag2_q + MAN_W'(1)) : smallMag2_q;
      out_q.sticky      <= sticky2_q;
      out_q.exp_l       <= exp2_q;
      out_q.special     <= spec2_q;
      out_q.special_res <= specRes2_q;
    end
  end

  assign out_valid   = v3_q;
  assign large_n     = out_q.large_n;
  assign small_n     = out_q.small_n;
  assign sticky      = out_q.sticky;
  assign exp_l       = out_q.exp_l;
  assign special     = out_q.special;
  assign special_res = out_q.special_res;

endmodule

// File: tb/tb_fp_align_unpack.sv
// Self-checking bench for fp_align_unpack: directed cases, stall/reset scenarios, and random traffic.
module tb_fp_align_unpack;
  import fp_pkg::*;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid, in_ready, out_valid, out_ready;
  logic [31:0]       a, b;
  logic [MAN_W-1:0]  large_n, small_n;
  logic              sticky, special;
  logic [EXP_W-1:0]  exp_l;
  logic [31:0]       special_res;

  int assertCount = 0;
  int failCount   = 0;

  fp_align_t expQ[$];
  fp_align_t heldOut;
  logic      stallPrev = 1'b0;
  logic      lastInXfer = 1'b0;
  logic [95:0] obs;

  fp_align_unpack dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .large_n(large_n), .small_n(small_n), .sticky(sticky), .exp_l(exp_l),
    .special(special), .special_res(special_res)
  );

  // Free-running clock, 10 time units per cycle
  always #5 clk = ~clk;

  // Flatten the visible outputs so stability and reset checks compare everything at once
  always_comb obs = {large_n, small_n, sticky, exp_l, special, special_res};

  // Hard time limit so the bench always terminates
  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [95:0] observed, input logic [95:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
    end
  endtask

  // Reference: follows the arithmetic description directly with wide integers
  function automatic fp_align_t refModel(input logic [31:0] x, input logic [31:0] y);
    fp_align_t r;
    logic [31:0] L, S;
    longint unsigned eL, eS, manL, manS, lm, sm, d, mod27, smallMag;
    logic nanX, nanY, infX, infY;
    L = (x[30:0] >= y[30:0]) ? x : y;
    S = (x[30:0] >= y[30:0]) ? y : x;
    eL   = (L[30:23] == 0) ? 1 : longint'(L[30:23]);
    eS   = (S[30:23] == 0) ? 1 : longint'(S[30:23]);
    manL = ((L[30:23] != 0) ? (64'd1 << 23) : 0) + longint'(L[22:0]);
    manS = ((S[30:23] != 0) ? (64'd1 << 23) : 0) + longint'(S[22:0]);
    d    = eL - eS;
    lm   = manL * 4;
    sm   = manS * 4;
    mod27 = 64'd1 << 27;
    if (d >= 27) begin
      smallMag = 0;
      r.sticky = (manS != 0);
    end else begin
      smallMag = sm / (64'd1 << d);
      r.sticky = (sm % (64'd1 << d)) != 0;
    end
    r.large_n = 27'(L[31] ? (mod27 - lm) % mod27 : lm);
    r.small_n = 27'(S[31] ? (mod27 - smallMag) % mod27 : smallMag);
    r.exp_l   = 8'(eL);
    nanX = (x[30:23] == 8'hFF) && (x[22:0] != 0);
    nanY = (y[30:23] == 8'hFF) && (y[22:0] != 0);
    infX = (x[30:23] == 8'hFF) && (x[22:0] == 0);
    infY = (y[30:23] == 8'hFF) && (y[22:0] == 0);
    r.special     = nanX || nanY || infX || infY;
    r.special_res = 32'h0;
    if (nanX || nanY || (infX && infY && x[31] != y[31])) r.special_res = 32'h7FC00000;
    else if (infX) r.special_res = x;
    else if (infY) r.special_res = y;
    return r;
  endfunction

  function automatic logic [31:0] genOperand(input logic [7:0] nearExp);
    logic [31:0] r;
    int k;
    r = $urandom;
    k = $urandom_range(0, 15);
    case (k)
      0: r[30:0] = '0;
      1: r[30:23] = 8'h00;
      2: r[30:0] = {8'hFF, 23'h0};
      3: r[30:23] = 8'hFF;
      4: r[30:23] = 8'($urandom_range(1, 254));
      default: r[30:23] = 8'(int'(nearExp) + $urandom_range(0, 40) - 20);
    endcase
    return r;
  endfunction

  // One clock: record transfers against the scoreboard, verify held outputs, then step
  task automatic tick();
    fp_align_t e;
    #1;
    if (stallPrev) checkOutput("hold_stable", obs, heldOut);
    lastInXfer = in_valid && in_ready;
    if (lastInXfer) expQ.push_back(refModel(a, b));
    if (out_valid && out_ready) begin
      checkOutput("out_has_pending", 96'(expQ.size() != 0), 96'd1);
      if (expQ.size() != 0) begin
        e = expQ.pop_front();
        checkOutput("large_n", 96'(large_n), 96'(e.large_n));
        checkOutput("small_n", 96'(small_n), 96'(e.small_n));
        checkOutput("sticky", 96'(sticky), 96'(e.sticky));
        checkOutput("exp_l", 96'(exp_l), 96'(e.exp_l));
        checkOutput("special", 96'(special), 96'(e.special));
        checkOutput("special_res", 96'(special_res), 96'(e.special_res));
      end
    end
    stallPrev = out_valid && !out_ready;
    heldOut   = obs;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic applyStimulus(input logic [31:0] x, input logic [31:0] y);
    int n;
    a = x; b = y; in_valid = 1'b1;
    n = 0;
    lastInXfer = 1'b0;
    while (!lastInXfer && n < 20) begin
      tick();
      n++;
    end
    checkOutput("accept_timeout", 96'(lastInXfer), 96'd1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    in_valid = 1'b0; out_ready = 1'b1;
    n = 0;
    while ((expQ.size() != 0 || out_valid) && n < 30) begin
      tick();
      n++;
    end
    checkOutput("drain_empty", 96'(expQ.size()), 96'd0);
  endtask

  // Directed pair with exact constants and latency check
  task automatic directed(input string tag, input logic [31:0] x, input logic [31:0] y,
                          input logic [95:0] expObs, input logic [95:0] mask);
    out_ready = 1'b1;
    applyStimulus(x, y);
    tick();
    #1 checkOutput({tag, "_lat2"}, 96'(out_valid), 96'd0);
    tick();
    #1 checkOutput({tag, "_valid"}, 96'(out_valid), 96'd1);
    checkOutput(tag, obs & mask, expObs & mask);
    drain();
  endtask

  initial begin
    logic [95:0] fullMask, specMask;
    logic [31:0] pairA[4], pairB[4];
    int idx, n;
    fullMask = '1;
    specMask = {27'h0, 27'h0, 1'b0, 8'h0, 1'b1, 32'hFFFFFFFF};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0;
    #1;
    checkOutput("reset_out_valid", 96'(out_valid), 96'd0);
    checkOutput("reset_outputs", obs, 96'd0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    #1 checkOutput("reset_in_ready", 96'(in_ready), 96'd1);
    @(negedge clk);

    directed("one_plus_one", 32'h3F800000, 32'h3F800000,
             {27'h2000000, 27'h2000000, 1'b0, 8'h7F, 1'b0, 32'h0}, fullMask);
    directed("half_minus_one", 32'h3F000000, 32'hBF800000,
             {27'h6000000, 27'h1000000, 1'b0, 8'h7F, 1'b0, 32'h0}, fullMask);
    directed("far_shift", 32'h3F800000, 32'h30800000,
             {27'h2000000, 27'h0, 1'b1, 8'h7F, 1'b0, 32'h0}, fullMask);
    directed("inf_minus_inf", 32'h7F800000, 32'hFF800000,
             {27'h0, 27'h0, 1'b0, 8'h0, 1'b1, 32'h7FC00000}, specMask);
    directed("inf_plus_one", 32'h7F800000, 32'h3F800000,
             {27'h0, 27'h0, 1'b0, 8'h0, 1'b1, 32'h7F800000}, specMask);

    $display("[TB] stall test");
    for (int i = 0; i < 4; i++) begin
      pairA[i] = 32'h40000000 + 32'(i) * 32'h00123457;
      pairB[i] = 32'hBE800000 + 32'(i) * 32'h00800001;
    end
    out_ready = 1'b0;
    idx = 0;
    for (int i = 0; i < 5; i++) begin
      in_valid = (idx < 4);
      a = pairA[idx % 4]; b = pairB[idx % 4];
      #1;
      if (i == 3) checkOutput("in_ready_full", 96'(in_ready), 96'd0);
      tick();
      if (lastInXfer) idx++;
    end
    out_ready = 1'b1;
    n = 0;
    while (idx < 4 && n < 20) begin
      in_valid = 1'b1;
      a = pairA[idx]; b = pairB[idx];
      tick();
      if (lastInXfer) idx++;
      n++;
    end
    checkOutput("stall_all_accepted", 96'(idx), 96'd4);
    drain();

    $display("[TB] reset with pairs in flight");
    in_valid = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      a = 32'h3F800000 + 32'(i); b = 32'hC0400000 - 32'(i);
      tick();
    end
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    checkOutput("midreset_out_valid", 96'(out_valid), 96'd0);
    checkOutput("midreset_outputs", obs, 96'd0);
    @(posedge clk); @(negedge clk);
    rst_n = 1'b1;
    expQ.delete();
    stallPrev = 1'b0;
    for (int i = 0; i < 6; i++) begin
      #1 checkOutput("no_stale_out", 96'(out_valid), 96'd0);
      tick();
    end

    $display("[TB] random traffic");
    for (int i = 0; i < 400; i++) begin
      logic [7:0] ne;
      ne = 8'($urandom_range(30, 220));
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 9) < 7);
      a = genOperand(ne);
      b = genOperand(ne);
      tick();
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
